mem_bus_responder: RTL and testbench
====================================

# mem_bus_responder

SoC-side responder for the CPU's byte-wide memory bus (`mem_a` / `mem_dout` / `mem_wr` / `mem_din` / `io_buffer_full`).
- Decodes each bus cycle to the 128 KB RAM port or to the memory-mapped I/O registers.
- Returns read data exactly one cycle after the request.
- Buffers UART output bytes in a TX FIFO and drives `io_buffer_full` back to the CPU.
- Provides the cycle counter and the program-stop indication.

## Interface
Parameters:
- `TX_AW`, default 4: TX FIFO address width; depth = 2^`TX_AW`.
- `FULL_MARGIN`, default 2: `io_buffer_full` asserts when free TX entries ≤ `FULL_MARGIN`.

Ports:
- `clk_in`  in  1: the only clock.
- `rst_in`  in  1: reset; synchronous, active-high.
- `rdy_in`  in  1: bus enable; bus accesses are ignored while low.
- `mem_a`  in  32: CPU address; only bits 17:0 are decoded.
- `mem_dout`  in  8: CPU write data.
- `mem_wr`  in  1: 1 = write, 0 = read.
- `mem_din`  out  8: read data to the CPU.
- `io_buffer_full`  out  1: TX FIFO nearly full.
- `ram_en`, `ram_wr`  out  1 each: RAM strobe and write enable.
- `ram_addr`  out  17: RAM address.
- `ram_wdata`  out  8: RAM write data.
- `ram_rdata`  in  8: RAM read data; the RAM's synchronous read gives 1-cycle latency.
- `rx_valid`  in  1, `rx_data`  in  8: UART RX byte available.
- `rx_pop`  out  1: 1-cycle pulse that consumes the current RX byte.
- `tx_valid`  out  1, `tx_data`  out  8, `tx_ready`  in  1: TX stream to the UART; a byte transfers when `tx_valid` and `tx_ready` are both high.
- `program_done`  out  1: sticky stop flag.
- `tx_overflow`  out  1: sticky flag set when a TX byte is dropped.

## Operation
Address decode (an access occurs only while `rdy_in`=1):
- `mem_a[17:16]` = 00 or 01: RAM. `ram_en`=1, `ram_addr`=`mem_a[16:0]`, `ram_wr`=`mem_wr`, `ram_wdata`=`mem_dout`. These outputs are combinational.
- `mem_a[17:16]` = 10: unmapped. Writes are dropped; reads return 0x00.
- `mem_a[17:16]` = 11: I/O, decoded on `mem_a[2:0]` as follows.
  - Read offset 0: returns `rx_data` if `rx_valid`, else 0x00. `rx_pop` pulses in the same cycle only if `rx_valid`.
  - Write offset 0: pushes `mem_dout` into the TX FIFO. A 0x00 byte is ignored.
  - Read offset 4: snapshots the 32-bit counter into `cnt_snap` and returns the counter's current bits [7:0].
  - Read offsets 5, 6, 7: return `cnt_snap` bytes 1, 2, 3.
  - Write offset 4: pushes 0x00 into the TX FIFO (the zero filter is bypassed) and sets `program_done`.
  - Any other I/O offset: reads return 0x00; writes are dropped.

Read return path:
- A 3-bit select register plus an 8-bit I/O data register capture the source in the request cycle.
- In the next cycle `mem_din` = `ram_rdata` when the select is RAM, otherwise the I/O data register.
- Writes and `rdy_in`=0 cycles set the select to zero, so `mem_din` = 0x00 the following cycle.

Cycle counter:
- 32-bit, increments every cycle after reset, independent of `rdy_in`.
- Wraps from 0xFFFFFFFF to 0.

TX FIFO:
- Circular buffer with `TX_AW`-bit pointers and a (`TX_AW`+1)-bit count.
- `tx_valid` = (count ≠ 0); `tx_data` = entry at the head.
- A push is accepted when count < depth, or when a pop happens in the same cycle.
- A rejected push drops the byte and sets `tx_overflow`.
- Simultaneous push and pop leaves count unchanged.
- Pointers wrap modulo the depth.
- `io_buffer_full` = (depth − count ≤ `FULL_MARGIN`). It is combinational from the count register.

`program_done` and `tx_overflow` clear only on reset. Writes after `program_done` are still serviced.

## Timing
Reset (`rst_in`=1 at a clock edge) clears the following:
- counter, `cnt_snap`, FIFO pointers and count;
- the select register (so `mem_din`=0x00), `program_done`, `tx_overflow`.

Resulting output values:
- `tx_valid`=0, `io_buffer_full`=0, `rx_pop`=0.
- `ram_en` is gated by `!rst_in`.

Reset mid-operation discards the FIFO contents and any pending read.

Latencies:
- Read: request in cycle N, data valid on `mem_din` in cycle N+1 and held until the next edge.
- Back-to-back reads are allowed every cycle.
- Write: committed at the end of cycle N. A TX byte written in N appears on `tx_valid` in N+1 if the FIFO was empty.
- `rdy_in`=0: no RAM strobe, no FIFO push, no `rx_pop`, no snapshot. The counter keeps running.

## Test plan
- Reset, then write 0x5A to 0x00010 and read 0x00010 in the next cycle → `mem_din`=0x5A one cycle after the read, `ram_wr` pulsed once.
- Write 0x41, 0x00, 0x42 to 0x30000 with `tx_ready`=1 → exactly 0x41 then 0x42 appear on `tx_data`; the 0x00 is filtered.
- Hold `tx_ready`=0 and write 14 nonzero bytes (depth 16) → `io_buffer_full` rises after the 14th push. 3 more writes → 2 accepted, 1 dropped, `tx_overflow`=1.
- Read 0x30004..0x30007 on consecutive cycles starting when counter = 0x000001FF → `mem_din` bytes are FF, 01, 00, 00, all from the same snapshot.
- `rx_valid`=1, `rx_data`=0x33, read 0x30000 → `mem_din`=0x33 next cycle and one `rx_pop` pulse. With `rx_valid`=0 the read returns 0x00 and no pop occurs.
- Write 0x30004 with `rdy_in`=0, then with `rdy_in`=1 → nothing happens on the first write. The second sets `program_done` and pushes 0x00 to TX. Asserting `rst_in` afterwards clears both `program_done` and the FIFO.

Source files
------------

// File: rtl/mem_bus_responder_if.sv
// CPU byte-wide memory bus: request address/data/direction from the CPU,
// read data and the TX back-pressure flag returned by the responder.
interface mem_bus_responder_if;
    logic        rdy_in;
    logic [31:0] mem_a;
    logic [7:0]  mem_dout;
    logic        mem_wr;
    logic [7:0]  mem_din;
    logic        io_buffer_full;

    modport master (
        output rdy_in, mem_a, mem_dout, mem_wr,
        input  mem_din, io_buffer_full
    );

    modport slave (
        input  rdy_in, mem_a, mem_dout, mem_wr,
        output mem_din, io_buffer_full
    );
endinterface

// File: rtl/mem_bus_responder.sv
// SoC-side responder: decodes CPU bus cycles to RAM or MMIO, returns read data one cycle later.
// Owns the UART TX FIFO (drives io_buffer_full), the free-running cycle counter and stop flag.
module mem_bus_responder #(
    parameter int TX_AW       = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic                 clk_in,
    input  logic                 rst_in,
    mem_bus_responder_if.slave   bus,

    output logic                 ram_en,
    output logic                 ram_wr,
    output logic [16:0]          ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic [7:0]           ram_rdata,

    input  logic                 rx_valid,
    input  logic [7:0]           rx_data,
    output logic                 rx_pop,

    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,

    output logic                 program_done,
    output logic                 tx_overflow
);

    localparam int              DEPTH      = 1 << TX_AW;
    localparam logic [TX_AW:0]  DEPTH_CNT  = (TX_AW + 1)'(DEPTH);
    localparam logic [TX_AW:0]  MARGIN_CNT = (TX_AW + 1)'(FULL_MARGIN);

    localparam logic [2:0] SEL_NONE = 3'd0;
    localparam logic [2:0] SEL_RAM  = 3'd1;
    localparam logic [2:0] SEL_IO   = 3'd2;

    localparam logic [2:0] OFF_DATA = 3'd0;
    localparam logic [2:0] OFF_CNT0 = 3'd4;
    localparam logic [2:0] OFF_CNT1 = 3'd5;
    localparam logic [2:0] OFF_CNT2 = 3'd6;
    localparam logic [2:0] OFF_CNT3 = 3'd7;

    // Read return path
    logic [2:0]  sel_q, sel_d;
    logic [7:0]  io_dat_q, io_dat_d;

    // Cycle counter and its snapshot
    logic [31:0] cnt_q, cnt_d;
    logic [31:0] cnt_snap_q, cnt_snap_d;

    // Sticky flags
    logic        done_q, done_d;
    logic        ovf_q, ovf_d;

    // TX FIFO
    logic [7:0]       tx_mem_q [DEPTH];
    logic [TX_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [TX_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;

    logic        acc;
    logic        ram_sel;
    logic        io_sel;
    logic        rd;
    logic [1:0]  region;
    logic [2:0]  io_off;
    logic        push_req;
    logic [7:0]  push_dat;
    logic        push_ok;
    logic        tx_pop;

    logic        unused_bits;
    assign unused_bits = ^{bus.mem_a[31:18], cnt_snap_q[7:0]};

    // Decode; every access is suppressed while reset is asserted.
    assign region  = bus.mem_a[17:16];
    assign io_off  = bus.mem_a[2:0];
    assign rd      = !bus.mem_wr;
    assign acc     = bus.rdy_in && !rst_in;
    assign ram_sel = acc && !region[1];
    assign io_sel  = acc && (region == 2'b11);

    assign ram_en    = ram_sel;
    assign ram_wr    = ram_sel && bus.mem_wr;
    assign ram_addr  = bus.mem_a[16:0];
    assign ram_wdata = bus.mem_dout;

    always_comb begin
        sel_d      = SEL_NONE;
        io_dat_d   = 8'h00;
        cnt_snap_d = cnt_snap_q;
        done_d     = done_q;
        rx_pop     = 1'b0;
        push_req   = 1'b0;
        push_dat   = bus.mem_dout;

        if (ram_sel && rd) begin
            sel_d = SEL_RAM;
        end

        if (io_sel) begin
            if (rd) begin
                sel_d = SEL_IO;
                case (io_off)
                    OFF_DATA: begin
                        if (rx_valid) begin
                            io_dat_d = rx_data;
                            rx_pop   = 1'b1;
                        end
                    end
                    OFF_CNT0: begin
                        cnt_snap_d = cnt_q;
                        io_dat_d   = cnt_q[7:0];
                    end
                    OFF_CNT1: io_dat_d = cnt_snap_q[15:8];
                    OFF_CNT2: io_dat_d = cnt_snap_q[23:16];
                    OFF_CNT3: io_dat_d = cnt_snap_q[31:24];
                    default:  io_dat_d = 8'h00;
                endcase
            end else begin
                case (io_off)
                    OFF_DATA: push_req = (bus.mem_dout != 8'h00);
                    OFF_CNT0: begin
                        // Stop write still emits a 0x00 so the host sees the terminator.
                        push_req = 1'b1;
                        push_dat = 8'h00;
                        done_d   = 1'b1;
                    end
                    default: push_req = 1'b0;
                endcase
            end
        end
    end

    always_comb begin
        bus.mem_din = 8'h00;
        case (sel_q)
            SEL_RAM: bus.mem_din = ram_rdata;
            SEL_IO:  bus.mem_din = io_dat_q;
            default: bus.mem_din = 8'h00;
        endcase
    end

    assign cnt_d = cnt_q + 32'd1;

    // FIFO bookkeeping; a push into a full FIFO is still taken if the head leaves this cycle.
    assign tx_valid = (tx_cnt_q != '0);
    assign tx_data  = tx_mem_q[rd_ptr_q];
    assign tx_pop   = tx_valid && tx_ready;
    assign push_ok  = push_req && ((tx_cnt_q < DEPTH_CNT) || tx_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        tx_cnt_d = tx_cnt_q;
        ovf_d    = ovf_q || (push_req && !push_ok);

        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (tx_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + 1'b1;
            2'b01:   tx_cnt_d = tx_cnt_q - 1'b1;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    assign bus.io_buffer_full = ((DEPTH_CNT - tx_cnt_q) <= MARGIN_CNT);
    assign program_done       = done_q;
    assign tx_overflow        = ovf_q;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            sel_q      <= SEL_NONE;
            io_dat_q   <= 8'h00;
            cnt_q      <= 32'd0;
            cnt_snap_q <= 32'd0;
            done_q     <= 1'b0;
            ovf_q      <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            tx_cnt_q   <= '0;
        end else begin
            sel_q      <= sel_d;
            io_dat_q   <= io_dat_d;
            cnt_q      <= cnt_d;
            cnt_snap_q <= cnt_snap_d;
            done_q     <= done_d;
            ovf_q      <= ovf_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            tx_cnt_q   <= tx_cnt_d;
        end
    end

    // Storage needs no reset: entries are only visible once the count covers them.
    always_ff @(posedge clk_in) begin
        if (push_ok) begin
            tx_mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: tb/tb_mem_bus_responder.sv
// Directed bench for mem_bus_responder: table of single-cycle bus vectors plus
// hand-written sequences for TX FIFO, counter snapshot, stop flag and reset.
module tb_mem_bus_responder;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        ram_en, ram_wr;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_pop;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_ready;
    logic        program_done;
    logic        tx_overflow;

    int tests  = 0;
    int failed = 0;

    mem_bus_responder_if bus_if ();

    mem_bus_responder #(.TX_AW(4), .FULL_MARGIN(2)) dut (
        .clk_in       (clk_in),
        .rst_in       (rst_in),
        .bus          (bus_if.slave),
        .ram_en       (ram_en),
        .ram_wr       (ram_wr),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .rx_valid     (rx_valid),
        .rx_data      (rx_data),
        .rx_pop       (rx_pop),
        .tx_valid     (tx_valid),
        .tx_data      (tx_data),
        .tx_ready     (tx_ready),
        .program_done (program_done),
        .tx_overflow  (tx_overflow)
    );

    always #5 clk_in = ~clk_in;

    // Synchronous-read RAM, one cycle latency
    logic [7:0] ram_mem [131072];
    always @(posedge clk_in) begin
        if (ram_en) begin
            if (ram_wr) ram_mem[ram_addr] <= ram_wdata;
            ram_rdata <= ram_mem[ram_addr];
        end
    end

    // UART side sink
    logic [7:0] txq [$];
    always @(posedge clk_in) begin
        if (!rst_in && tx_valid && tx_ready) txq.push_back(tx_data);
    end

    typedef struct {
        logic        rdy;
        logic [31:0] a;
        logic [7:0]  dout;
        logic        wr;
        logic        rxv;
        logic [7:0]  rxd;
        logic        e_en;
        logic        e_wr;
        logic        e_pop;
        logic [7:0]  e_din;
    } vec_t;

    vec_t vecs [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic rdy, input logic [31:0] a, input logic [7:0] d, input logic wr);
        bus_if.rdy_in   = rdy;
        bus_if.mem_a    = a;
        bus_if.mem_dout = d;
        bus_if.mem_wr   = wr;
    endtask

    task automatic idle();
        drive(1'b0, 32'h0, 8'h00, 1'b0);
    endtask

    task automatic do_reset();
        @(negedge clk_in);
        idle();
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
    endtask

    initial begin
        //            rdy  addr          dout   wr   rxv  rxd    en   wr   pop  din
        vecs[0]  = '{1'b1, 32'h0000_0010, 8'h5A, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[1]  = '{1'b1, 32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A};
        vecs[2]  = '{1'b1, 32'h0001_FFFF, 8'hC3, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00};
        vecs[3]  = '{1'b1, 32'h0001_FFFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3};
        vecs[4]  = '{1'b1, 32'h0002_0010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[5]  = '{1'b1, 32'h0002_0010, 8'h77, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[6]  = '{1'b1, 32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A};
        vecs[7]  = '{1'b0, 32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[8]  = '{1'b0, 32'h0000_0010, 8'h11, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[9]  = '{1'b1, 32'h0000_0010, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h5A};
        vecs[10] = '{1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h33, 1'b0, 1'b0, 1'b1, 8'h33};
        vecs[11] = '{1'b1, 32'h0003_0000, 8'h00, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[12] = '{1'b0, 32'h0003_0000, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[13] = '{1'b1, 32'h0003_0001, 8'h00, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[14] = '{1'b1, 32'h0003_0002, 8'h99, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 8'h00};
        vecs[15] = '{1'b1, 32'hABC3_0000, 8'h00, 1'b0, 1'b1, 8'h66, 1'b0, 1'b0, 1'b1, 8'h66};
        vecs[16] = '{1'b1, 32'hFFF1_FFFF, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'hC3};

        rst_in   = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        tx_ready = 1'b0;
        idle();

        // Reset state, with a RAM read presented during reset
        @(negedge clk_in);
        drive(1'b1, 32'h0000_0010, 8'h00, 1'b0);
        #1;
        chk("ram_en_in_reset", ram_en, 1'b0);
        @(negedge clk_in);
        rst_in = 1'b0;
        idle();
        #1;
        chk("rst_mem_din", bus_if.mem_din, 8'h00);
        chk("rst_tx_valid", tx_valid, 1'b0);
        chk("rst_buf_full", bus_if.io_buffer_full, 1'b0);
        chk("rst_rx_pop", rx_pop, 1'b0);
        chk("rst_done", program_done, 1'b0);
        chk("rst_ovf", tx_overflow, 1'b0);

        // Table of single-cycle bus vectors
        for (int i = 0; i < 17; i++) begin
            @(negedge clk_in);
            if (i > 0) chk($sformatf("vec%0d_din", i - 1), bus_if.mem_din, vecs[i-1].e_din);
            drive(vecs[i].rdy, vecs[i].a, vecs[i].dout, vecs[i].wr);
            rx_valid = vecs[i].rxv;
            rx_data  = vecs[i].rxd;
            #1;
            chk($sformatf("vec%0d_ram_en", i), ram_en, vecs[i].e_en);
            chk($sformatf("vec%0d_ram_wr", i), ram_wr, vecs[i].e_wr);
            chk($sformatf("vec%0d_rx_pop", i), rx_pop, vecs[i].e_pop);
            if (vecs[i].e_en) chk($sformatf("vec%0d_addr", i), ram_addr, vecs[i].a[16:0]);
            if (vecs[i].e_wr) chk($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].dout);
        end
        @(negedge clk_in);
        chk("vec16_din", bus_if.mem_din, vecs[16].e_din);
        idle();
        rx_valid = 1'b0;
        #1;
        chk("table_no_tx", tx_valid, 1'b0);

        // Zero filter on TX data writes
        txq.delete();
        tx_ready = 1'b1;
        @(negedge clk_in);
        drive(1'b1, 32'h0003_0000, 8'h41, 1'b1);
        @(negedge clk_in);
        chk("tx_first_vld", tx_valid, 1'b1);
        chk("tx_first_dat", tx_data, 8'h41);
        drive(1'b1, 32'h0003_0000, 8'h00, 1'b1);
        @(negedge clk_in);
        drive(1'b1, 32'h0003_0000, 8'h42, 1'b1);
        @(negedge clk_in);
        idle();
        repeat (4) @(negedge clk_in);
        chk("filter_count", txq.size(), 2);
        if (txq.size() == 2) begin
            chk("filter_b0", txq[0], 8'h41);
            chk("filter_b1", txq[1], 8'h42);
        end

        // Fill with tx_ready low: near-full flag and overflow
        tx_ready = 1'b0;
        txq.delete();
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk_in);
            drive(1'b1, 32'h0003_0000, 8'(i), 1'b1);
            @(negedge clk_in);
            idle();
            if (i == 13) chk("full_after13", bus_if.io_buffer_full, 1'b0);
            if (i == 14) chk("full_after14", bus_if.io_buffer_full, 1'b1);
            if (i == 16) chk("ovf_after16", tx_overflow, 1'b0);
            if (i == 17) chk("ovf_after17", tx_overflow, 1'b1);
        end
        tx_ready = 1'b1;
        repeat (20) @(negedge clk_in);
        chk("drain_count", txq.size(), 16);
        if (txq.size() == 16) begin
            for (int k = 0; k < 16; k++) chk($sformatf("drain_b%0d", k), txq[k], 32'(k + 1));
        end
        chk("drain_empty", tx_valid, 1'b0);
        chk("drain_not_full", bus_if.io_buffer_full, 1'b0);
        tx_ready = 1'b0;

        // Counter snapshot: counter is k at the k-th falling edge after reset release
        do_reset();
        repeat (511) @(negedge clk_in);
        drive(1'b1, 32'h0003_0004, 8'h00, 1'b0);
        @(negedge clk_in);
        chk("cnt_b0", bus_if.mem_din, 8'hFF);
        drive(1'b1, 32'h0003_0005, 8'h00, 1'b0);
        @(negedge clk_in);
        chk("cnt_b1", bus_if.mem_din, 8'h01);
        drive(1'b1, 32'h0003_0006, 8'h00, 1'b0);
        @(negedge clk_in);
        chk("cnt_b2", bus_if.mem_din, 8'h00);
        drive(1'b1, 32'h0003_0007, 8'h00, 1'b0);
        @(negedge clk_in);
        chk("cnt_b3", bus_if.mem_din, 8'h00);
        idle();

        // Stop write gated by rdy_in, then reset clears it
        @(negedge clk_in);
        drive(1'b0, 32'h0003_0004, 8'h00, 1'b1);
        @(negedge clk_in);
        idle();
        chk("stop_rdy0_done", program_done, 1'b0);
        chk("stop_rdy0_tx", tx_valid, 1'b0);
        drive(1'b1, 32'h0003_0004, 8'h00, 1'b1);
        @(negedge clk_in);
        idle();
        chk("stop_done", program_done, 1'b1);
        chk("stop_tx_vld", tx_valid, 1'b1);
        chk("stop_tx_dat", tx_data, 8'h00);
        drive(1'b1, 32'h0003_0000, 8'h21, 1'b1);
        @(negedge clk_in);
        idle();
        chk("post_stop_write", tx_data, 8'h00);
        do_reset();
        #1;
        chk("reset_clears_done", program_done, 1'b0);
        chk("reset_clears_fifo", tx_valid, 1'b0);

        // Reset during a read request discards the pending data
        @(negedge clk_in);
        drive(1'b1, 32'h0000_0010, 8'h00, 1'b0);
        @(negedge clk_in);
        chk("read_before_rst", bus_if.mem_din, 8'h5A);
        rst_in = 1'b1;
        @(negedge clk_in);
        rst_in = 1'b0;
        idle();
        #1;
        chk("read_killed_by_rst", bus_if.mem_din, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
